// File: rtl/gsim_pkg.sv
// Shared constants, FSM encoding and helpers for the GSIM host-side stream driver.
package gsim_pkg;
   localparam int N           = 16;
   localparam int AW          = 4;
   localparam int BW          = 16;
   localparam int XW          = 32;
   localparam int FRAC_W      = 16;
   localparam int CW          = 16;
   localparam int TIMEOUT_CYC = 8192;
   localparam int WDW         = $clog2(TIMEOUT_CYC) + 1;

   localparam logic [AW-1:0]  LAST_IDX = AW'(N - 1);
   localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEND = 3'd1,
      WAIT = 3'd2,
      RECV = 3'd3,
      DONE = 3'd4
   } state_t;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/gsim_result_buf.sv
// N x XW result register file: one write port, one read port with 1-cycle registered latency.
// A read of the entry written in the same cycle returns the previous contents.
module gsim_result_buf
   import gsim_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [XW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [XW-1:0] o_rdata
);
   logic [XW-1:0] r_mem [N];
   logic [XW-1:0] r_rdata;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < N; i++) r_mem[i] <= '0;
         r_rdata <= '0;
      end else begin
         if (i_we) r_mem[i_waddr] <= i_wdata;
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/gsim_stream_driver.sv
// Streams N stored b words to GSIM as one ungapped in_en burst, then captures N x words
// (out_valid stalls hold the index) and reports done/latency. Watchdog: GSIM_DRV_TIMEOUT_EN.
module gsim_stream_driver
   import gsim_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_cfg_we,
   input  logic [AW-1:0] i_cfg_addr,
   input  logic [BW-1:0] i_cfg_wdata,
   input  logic          i_start,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_timeout,
   output logic [CW-1:0] o_lat_cnt,
   output logic          o_in_en,
   output logic [BW-1:0] o_b_in,
   input  logic          i_out_valid,
   input  logic [XW-1:0] i_x_in,
   input  logic [AW-1:0] i_rd_addr,
   output logic [XW-1:0] o_rd_data
);
   state_t        r_state, w_state_nx;
   logic [AW-1:0] r_idx, w_idx_nx, w_idx_inc;
   logic          r_busy, w_busy_nx;
   logic          r_done, w_done_nx;
   logic          r_in_en, w_in_en_nx;
   logic [BW-1:0] r_b_in, w_b_in_nx, w_b_first;
   logic [CW-1:0] r_lat, w_lat_nx;
   logic [BW-1:0] r_b_mem [N];
   logic          w_cfg_wr, w_start;
   logic          w_buf_we;
   logic [AW-1:0] w_buf_waddr;
`ifdef GSIM_DRV_TIMEOUT_EN
   logic [WDW-1:0] r_wd, w_wd_nx;
   logic           r_timeout, w_timeout_nx;
`endif

   assign w_cfg_wr  = i_cfg_we & ~r_busy;
   assign w_start   = i_start & ~r_busy;
   assign w_idx_inc = r_idx + 1'b1;
   // A b[0] write coincident with start must be the value that goes out on beat 0
   assign w_b_first = (w_cfg_wr && i_cfg_addr == '0) ? i_cfg_wdata : r_b_mem[0];

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < N; i++) r_b_mem[i] <= '0;
      end else if (w_cfg_wr) begin
         r_b_mem[i_cfg_addr] <= i_cfg_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_in_en <= 1'b0;
         r_b_in  <= '0;
         r_lat   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_busy  <= w_busy_nx;
         r_done  <= w_done_nx;
         r_in_en <= w_in_en_nx;
         r_b_in  <= w_b_in_nx;
         r_lat   <= w_lat_nx;
      end
   end

`ifdef GSIM_DRV_TIMEOUT_EN
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_wd      <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_wd      <= w_wd_nx;
         r_timeout <= w_timeout_nx;
      end
   end
`endif

   always_comb begin
      w_state_nx  = r_state;
      w_idx_nx    = r_idx;
      w_busy_nx   = r_busy;
      w_done_nx   = r_done;
      w_in_en_nx  = 1'b0;
      w_b_in_nx   = '0;
      w_lat_nx    = r_lat;
      w_buf_we    = 1'b0;
      w_buf_waddr = r_idx;

      case (r_state)
         IDLE, DONE: begin
            if (w_start) begin
               w_state_nx = SEND;
               w_idx_nx   = '0;
               w_busy_nx  = 1'b1;
               w_done_nx  = 1'b0;
               w_lat_nx   = '0;
               w_in_en_nx = 1'b1;
               w_b_in_nx  = w_b_first;
            end
         end
         SEND: begin
            if (r_idx == LAST_IDX) begin
               w_state_nx = WAIT;
               w_idx_nx   = '0;
            end else begin
               w_idx_nx   = w_idx_inc;
               w_in_en_nx = 1'b1;
               w_b_in_nx  = r_b_mem[w_idx_inc];
            end
         end
         WAIT: begin
            w_lat_nx = sat_inc(r_lat);
            if (i_out_valid) begin
               w_buf_we    = 1'b1;
               w_buf_waddr = '0;
               w_idx_nx    = AW'(1);
               w_state_nx  = RECV;
            end
         end
         RECV: begin
            if (i_out_valid) begin
               w_buf_we = 1'b1;
               if (r_idx == LAST_IDX) begin
                  w_state_nx = DONE;
                  w_idx_nx   = '0;
                  w_busy_nx  = 1'b0;
                  w_done_nx  = 1'b1;
               end else begin
                  w_idx_nx = w_idx_inc;
               end
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_idx_nx   = '0;
            w_busy_nx  = 1'b0;
         end
      endcase

`ifdef GSIM_DRV_TIMEOUT_EN
      w_wd_nx      = r_wd;
      w_timeout_nx = r_timeout;
      if (w_start) w_timeout_nx = 1'b0;
      if (r_state == SEND) begin
         w_wd_nx = '0;
      end else if (r_state == WAIT || r_state == RECV) begin
         w_wd_nx = r_wd + 1'b1;
         // A word arriving on the expiry cycle still lands; completion takes priority
         if (r_wd == WD_LAST && w_state_nx != DONE) begin
            w_state_nx   = DONE;
            w_idx_nx     = '0;
            w_busy_nx    = 1'b0;
            w_done_nx    = 1'b1;
            w_timeout_nx = 1'b1;
         end
      end
`endif
   end

   gsim_result_buf u_result_buf (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_we    (w_buf_we),
      .i_waddr (w_buf_waddr),
      .i_wdata (i_x_in),
      .i_raddr (i_rd_addr),
      .o_rdata (o_rd_data)
   );

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_lat_cnt = r_lat;
   assign o_in_en   = r_in_en;
   assign o_b_in    = r_b_in;
`ifdef GSIM_DRV_TIMEOUT_EN
   assign o_timeout = r_timeout;
`else
   assign o_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_gsim_stream_driver.sv
// Directed bench for gsim_stream_driver: burst shape, capture, stalls, busy gating, reset abort.
module tb_gsim_stream_driver;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic        start;
   logic        busy, done, timeout;
   logic [15:0] lat_cnt;
   logic        in_en;
   logic [15:0] b_in;
   logic        out_valid;
   logic [31:0] x_in;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data;

   int          n_run  = 0;
   int          n_fail = 0;
   logic [15:0] exp_b [16];

   always #5 clk = ~clk;

   gsim_stream_driver dut (
      .i_clk       (clk),
      .i_reset     (rst_n),
      .i_cfg_we    (cfg_we),
      .i_cfg_addr  (cfg_addr),
      .i_cfg_wdata (cfg_wdata),
      .i_start     (start),
      .o_busy      (busy),
      .o_done      (done),
      .o_timeout   (timeout),
      .o_lat_cnt   (lat_cnt),
      .o_in_en     (in_en),
      .o_b_in      (b_in),
      .i_out_valid (out_valid),
      .i_x_in      (x_in),
      .i_rd_addr   (rd_addr),
      .o_rd_data   (rd_data)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
      out_valid = 1'b0; x_in = '0; rd_addr = '0;
      step(); step();
      n_run++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
      n_run++; if (done !== 1'b0)     begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
      n_run++; if (timeout !== 1'b0)  begin n_fail++; $display("FAIL rst_timeout got %b exp 0", timeout); end
      n_run++; if (in_en !== 1'b0)    begin n_fail++; $display("FAIL rst_in_en got %b exp 0", in_en); end
      n_run++; if (b_in !== 16'h0)    begin n_fail++; $display("FAIL rst_b_in got %h exp 0", b_in); end
      n_run++; if (lat_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_lat got %0d exp 0", lat_cnt); end
      n_run++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_rd_data got %h exp 0", rd_data); end
      rst_n = 1'b1;
      step();
   endtask

   // Starts a solve and checks the full 16-beat burst against exp_b; ends in the first WAIT cycle.
   task automatic do_burst(input bit coincide);
      start = 1'b1;
      if (coincide) begin cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 16'h7FFF; end
      n_run++; if (in_en !== 1'b0) begin n_fail++; $display("FAIL burst_early got in_en=%b exp 0", in_en); end
      step();
      start = 1'b0; cfg_we = 1'b0;
      n_run++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL start_busy got %b exp 1", busy); end
      n_run++; if (done !== 1'b0)     begin n_fail++; $display("FAIL start_done_clr got %b exp 0", done); end
      n_run++; if (timeout !== 1'b0)  begin n_fail++; $display("FAIL start_to_clr got %b exp 0", timeout); end
      n_run++; if (lat_cnt !== 16'h0) begin n_fail++; $display("FAIL start_lat_clr got %0d exp 0", lat_cnt); end
      for (int k = 0; k < 16; k++) begin
         n_run++;
         if (in_en !== 1'b1 || b_in !== exp_b[k]) begin
            n_fail++; $display("FAIL beat%0d got in_en=%b b_in=%h exp in_en=1 b_in=%h", k, in_en, b_in, exp_b[k]);
         end
         step();
      end
      n_run++; if (in_en !== 1'b0 || b_in !== 16'h0) begin
         n_fail++; $display("FAIL burst_end got in_en=%b b_in=%h exp 0/0000", in_en, b_in);
      end
   endtask

   // GSIM model: first word lat cycles after the last beat, words (k<<16)^mask, optional 3-cycle stall.
   task automatic do_response(input int lat, input int stall_after, input logic [31:0] mask,
                              input logic [31:0] old0, input bit poke);
      logic [31:0] w;
      for (int c = 1; c < lat; c++) begin
         if (poke && c == 3) begin
            cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 16'h7FFF; start = 1'b1;
         end
         step();
         cfg_we = 1'b0; start = 1'b0;
         if (poke && c == 3) begin
            n_run++; if (in_en !== 1'b0) begin n_fail++; $display("FAIL ign_start_in_en got %b exp 0", in_en); end
            n_run++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL ign_start_busy got %b exp 1", busy); end
         end
      end
      rd_addr = 4'd0; out_valid = 1'b1; x_in = mask;
      step();
      n_run++; if (lat_cnt !== 16'(lat)) begin n_fail++; $display("FAIL lat_cnt got %0d exp %0d", lat_cnt, lat); end
      n_run++; if (rd_data !== old0) begin n_fail++; $display("FAIL rd_same_cycle got %h exp %h", rd_data, old0); end
      for (int k = 1; k < 16; k++) begin
         w = (32'(k) << 16) ^ mask;
         out_valid = 1'b1; x_in = w;
         step();
         if (k == stall_after) begin
            out_valid = 1'b0; x_in = 32'hDEADBEEF;
            repeat (3) begin
               step();
               n_run++; if (busy !== 1'b1 || done !== 1'b0) begin
                  n_fail++; $display("FAIL stall_state got busy=%b done=%b exp 1/0", busy, done);
               end
            end
         end
      end
      out_valid = 1'b0; x_in = '0;
      n_run++; if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL solve_done got done=%b busy=%b exp 1/0", done, busy);
      end
      n_run++; if (rd_data !== mask) begin n_fail++; $display("FAIL rd_word0_new got %h exp %h", rd_data, mask); end
      n_run++; if (lat_cnt !== 16'(lat)) begin n_fail++; $display("FAIL lat_hold got %0d exp %0d", lat_cnt, lat); end
   endtask

   task automatic check_buf(input logic [31:0] mask);
      logic [31:0] w;
      for (int k = 0; k < 16; k++) begin
         rd_addr = 4'(k);
         if (k > 0) begin
            w = (32'(k - 1) << 16) ^ mask;
            n_run++; if (rd_data !== w) begin n_fail++; $display("FAIL rd_latency%0d got %h exp %h", k, rd_data, w); end
         end
         step();
         w = (32'(k) << 16) ^ mask;
         n_run++; if (rd_data !== w) begin n_fail++; $display("FAIL buf%0d got %h exp %h", k, rd_data, w); end
      end
   endtask

   task automatic test_load_send();
      for (int i = 0; i < 16; i++) begin
         cfg_we = 1'b1; cfg_addr = 4'(i); cfg_wdata = 16'(i + 1); exp_b[i] = 16'(i + 1);
         step();
      end
      cfg_we = 1'b0;
      do_burst(1'b0);
   endtask

   task automatic test_response();
      do_response(50, -1, 32'h0, 32'h0, 1'b0);
      out_valid = 1'b1; x_in = 32'h12345678;
      step(); step();
      out_valid = 1'b0;
      n_run++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_hold got %b exp 1", done); end
      check_buf(32'h0);
   endtask

   task automatic test_stall();
      do_burst(1'b0);
      do_response(20, 5, 32'hF000_0000, 32'h0, 1'b0);
      check_buf(32'hF000_0000);
   endtask

   task automatic test_busy_ignore();
      do_burst(1'b0);
      do_response(12, -1, 32'h0000_00A5, 32'hF000_0000, 1'b1);
      do_burst(1'b0);
      do_response(8, -1, 32'h5A00_0000, 32'h0000_00A5, 1'b0);
   endtask

   task automatic test_rewrite_in_done();
      exp_b[0] = 16'h7FFF;
      do_burst(1'b1);
      do_response(9, -1, 32'h0000_0003, 32'h5A00_0000, 1'b0);
      check_buf(32'h0000_0003);
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (7) step();
      n_run++; if (in_en !== 1'b1 || b_in !== exp_b[7]) begin
         n_fail++; $display("FAIL mid_beat7 got in_en=%b b_in=%h exp 1/%h", in_en, b_in, exp_b[7]);
      end
      #2 rst_n = 1'b0;
      #1;
      n_run++; if (in_en !== 1'b0) begin n_fail++; $display("FAIL async_in_en got %b exp 0", in_en); end
      n_run++; if (busy !== 1'b0 || b_in !== 16'h0) begin
         n_fail++; $display("FAIL async_state got busy=%b b_in=%h exp 0/0000", busy, b_in);
      end
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         rd_addr = 4'(k);
         step();
         n_run++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL buf_clr%0d got %h exp 0", k, rd_data); end
      end
      for (int i = 0; i < 16; i++) exp_b[i] = 16'h0;
      do_burst(1'b0);
      do_response(6, -1, 32'h0000_0001, 32'h0, 1'b0);
   endtask

`ifdef GSIM_DRV_TIMEOUT_EN
   task automatic test_timeout();
      do_burst(1'b0);
      repeat (8191) step();
      n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL to_early got done=%b exp 0", done); end
      step();
      n_run++; if (timeout !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL to_fire got to=%b done=%b busy=%b exp 1/1/0", timeout, done, busy);
      end
      n_run++; if (lat_cnt !== 16'd8192) begin n_fail++; $display("FAIL to_lat got %0d exp 8192", lat_cnt); end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      test_reset();
      test_load_send();
      test_response();
      test_stall();
      test_busy_ignore();
      test_rewrite_in_done();
      test_reset_mid();
`ifdef GSIM_DRV_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
